// File: rtl/pll_reset_pkg.sv
// Shared types and constants for the PLL reset sequencer.
package pll_reset_pkg;

  typedef enum logic [1:0] {
    WAIT_LOCK,
    STABLE,
    RELEASE,
    RUN
  } rs_state_t;

  localparam int LOSS_CNT_W = 8;

endpackage

// File: rtl/sync_ff2.sv
// Two-flop synchroniser for a single asynchronous level; output resets to 0.
module sync_ff2 (
  input  logic clk,
  input  logic rst_n,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      meta <= 1'b0;
      q    <= 1'b0;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/pll_reset_seq.sv
// Staged, synchronously released reset generator driven by a filtered PLL lock.
//   state     | meaning
//   WAIT_LOCK | all resets held, waiting for synchronised lock
//   STABLE    | lock seen, counting consecutive locked cycles
//   RELEASE   | releasing one reset bit every STAGE_GAP cycles
//   RUN       | all stages released, ready high
module pll_reset_seq
  import pll_reset_pkg::*;
#(
  parameter int LOCK_STABLE_CYCLES = 1024,
  parameter int STAGES             = 3,
  parameter int STAGE_GAP          = 16,
  parameter int LOSS_FILTER        = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  locked,
  input  logic                  soft_rst_req,
  output logic [STAGES-1:0]     rst_n_out,
  output logic                  ready,
  output logic [LOSS_CNT_W-1:0] lock_loss_count
);

  localparam int CNT_MAX = (LOCK_STABLE_CYCLES > STAGE_GAP) ? LOCK_STABLE_CYCLES : STAGE_GAP;
  localparam int CNT_W   = $clog2(CNT_MAX);
  localparam int LF_W    = $clog2(LOSS_FILTER + 1);

  localparam logic [CNT_W-1:0]  STABLE_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]  GAP_LAST    = CNT_W'(STAGE_GAP - 1);
  localparam logic [LF_W-1:0]   LOSS_LAST   = LF_W'(LOSS_FILTER - 1);
  localparam logic [STAGES-1:0] ALL_ON      = '1;

  rs_state_t             state, state_nxt;
  logic [CNT_W-1:0]      cnt, cnt_nxt;
  logic [LF_W-1:0]       loss, loss_nxt;
  logic [STAGES-1:0]     rst_nxt, rst_shift;
  logic                  ready_nxt;
  logic [LOSS_CNT_W-1:0] llc_nxt;
  logic                  lock_s;
  logic                  lost;

  sync_ff2 u_lock_sync (
    .clk   (clk),
    .rst_n (resetn),
    .d     (locked),
    .q     (lock_s)
  );

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state           <= WAIT_LOCK;
      cnt             <= '0;
      loss            <= '0;
      rst_n_out       <= '0;
      ready           <= 1'b0;
      lock_loss_count <= '0;
    end else begin
      state           <= state_nxt;
      cnt             <= cnt_nxt;
      loss            <= loss_nxt;
      rst_n_out       <= rst_nxt;
      ready           <= ready_nxt;
      lock_loss_count <= llc_nxt;
    end
  end

  // Next stage pattern: shift in one more released bit above those already high.
  assign rst_shift = STAGES'({rst_n_out, 1'b1});
  assign lost      = !lock_s && (loss == LOSS_LAST);

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    loss_nxt  = loss;
    rst_nxt   = rst_n_out;
    ready_nxt = ready;
    llc_nxt   = lock_loss_count;

    case (state)
      WAIT_LOCK: begin
        rst_nxt   = '0;
        ready_nxt = 1'b0;
        cnt_nxt   = '0;
        loss_nxt  = '0;
        if (lock_s) state_nxt = STABLE;
      end

      STABLE: begin
        loss_nxt = '0;
        if (!lock_s) begin
          state_nxt = WAIT_LOCK;
          cnt_nxt   = '0;
        end else if (soft_rst_req) begin
          cnt_nxt = '0;
        end else if (cnt == STABLE_LAST) begin
          cnt_nxt = '0;
          rst_nxt = STAGES'(1);
          if (STAGES == 1) begin
            state_nxt = RUN;
            ready_nxt = 1'b1;
          end else begin
            state_nxt = RELEASE;
          end
        end else begin
          cnt_nxt = cnt + CNT_W'(1);
        end
      end

      RELEASE, RUN: begin
        loss_nxt = lock_s ? '0 : loss + LF_W'(1);
        // Filtered loss outranks a coincident soft request.
        if (lost) begin
          state_nxt = WAIT_LOCK;
          rst_nxt   = '0;
          ready_nxt = 1'b0;
          cnt_nxt   = '0;
          loss_nxt  = '0;
          if (lock_loss_count != '1) llc_nxt = lock_loss_count + LOSS_CNT_W'(1);
        end else if (soft_rst_req) begin
          state_nxt = STABLE;
          rst_nxt   = '0;
          ready_nxt = 1'b0;
          cnt_nxt   = '0;
          loss_nxt  = '0;
        end else if (state == RELEASE) begin
          if (cnt == GAP_LAST) begin
            cnt_nxt = '0;
            rst_nxt = rst_shift;
            if (rst_shift == ALL_ON) begin
              state_nxt = RUN;
              ready_nxt = 1'b1;
            end
          end else begin
            cnt_nxt = cnt + CNT_W'(1);
          end
        end
      end

      default: state_nxt = WAIT_LOCK;
    endcase
  end

endmodule

// File: tb/tb_pll_reset_seq.sv
// Directed bench for pll_reset_seq: expectations are queued with a target edge and checked there.
module tb_pll_reset_seq;

  localparam int LSC = 8;
  localparam int ST  = 3;
  localparam int GAP = 4;
  localparam int LF  = 4;

  logic          clk = 1'b0;
  logic          resetn = 1'b0;
  logic          locked = 1'b0;
  logic          soft_rst_req = 1'b0;
  logic [ST-1:0] rst_n_out;
  logic          ready;
  logic [7:0]    lock_loss_count;

  int edge_cnt = 0;
  int tests_run = 0;
  int tests_failed = 0;

  typedef struct {
    int            at;
    string         tag;
    logic [ST-1:0] rst;
    logic          rdy;
    logic [7:0]    llc;
  } exp_t;

  exp_t sb[$];

  pll_reset_seq #(
    .LOCK_STABLE_CYCLES (LSC),
    .STAGES             (ST),
    .STAGE_GAP          (GAP),
    .LOSS_FILTER        (LF)
  ) dut (
    .clk             (clk),
    .resetn          (resetn),
    .locked          (locked),
    .soft_rst_req    (soft_rst_req),
    .rst_n_out       (rst_n_out),
    .ready           (ready),
    .lock_loss_count (lock_loss_count)
  );

  always #5 clk = ~clk;
  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Returns 1 time unit after the requested edge (immediately if already past it).
  task automatic at_edge(input int e);
    while (edge_cnt < e) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_at(input int e, input string tag, input logic [ST-1:0] r,
                           input logic rd, input logic [7:0] c);
    exp_t x;
    x.at  = e;
    x.tag = tag;
    x.rst = r;
    x.rdy = rd;
    x.llc = c;
    sb.push_back(x);
  endtask

  task automatic drain();
    exp_t x;
    while (sb.size() > 0) begin
      x = sb.pop_front();
      at_edge(x.at);
      tests_run++;
      assert (rst_n_out === x.rst) else begin
        tests_failed++;
        $error("FAIL %s rst_n_out observed=%b expected=%b edge=%0d", x.tag, rst_n_out, x.rst, edge_cnt);
      end
      tests_run++;
      assert (ready === x.rdy) else begin
        tests_failed++;
        $error("FAIL %s ready observed=%b expected=%b edge=%0d", x.tag, ready, x.rdy, edge_cnt);
      end
      tests_run++;
      assert (lock_loss_count === x.llc) else begin
        tests_failed++;
        $error("FAIL %s lock_loss_count observed=%0d expected=%0d edge=%0d", x.tag, lock_loss_count, x.llc, edge_cnt);
      end
    end
  endtask

  initial begin
    #200000;
    $display("FAIL timeout edge=%0d", edge_cnt);
    $fatal(1, "[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
  end

  initial begin
    int b;

    // Reset state, then release of resetn.
    expect_at(3, "reset", 3'b000, 1'b0, 8'd0);
    drain();
    resetn = 1'b1;

    // Lock first sampled at edge 10: stages at 20, 24, 28.
    at_edge(9);
    locked = 1'b1;
    expect_at(19, "pre_rel",  3'b000, 1'b0, 8'd0);
    expect_at(20, "stage0",   3'b001, 1'b0, 8'd0);
    expect_at(23, "gap0",     3'b001, 1'b0, 8'd0);
    expect_at(24, "stage1",   3'b011, 1'b0, 8'd0);
    expect_at(27, "gap1",     3'b011, 1'b0, 8'd0);
    expect_at(28, "stage2",   3'b111, 1'b1, 8'd0);
    drain();

    // Three-cycle glitch is filtered out.
    at_edge(30);
    locked = 1'b0;
    at_edge(33);
    locked = 1'b1;
    expect_at(35, "glitch3_a", 3'b111, 1'b1, 8'd0);
    expect_at(36, "glitch3_b", 3'b111, 1'b1, 8'd0);
    expect_at(39, "glitch3_c", 3'b111, 1'b1, 8'd0);
    drain();

    // Four-cycle loss: sampled low at 41, resets drop after 46.
    at_edge(40);
    locked = 1'b0;
    expect_at(45, "loss_pre", 3'b111, 1'b1, 8'd0);
    expect_at(46, "loss4",    3'b000, 1'b0, 8'd1);
    drain();

    // Relock, single-cycle dropout in STABLE at count 5 restarts the wait.
    at_edge(49);
    locked = 1'b1;
    at_edge(55);
    locked = 1'b0;
    at_edge(56);
    locked = 1'b1;
    expect_at(60, "drop_no_rel", 3'b000, 1'b0, 8'd1);
    expect_at(66, "drop_pre",    3'b000, 1'b0, 8'd1);
    expect_at(67, "drop_st0",    3'b001, 1'b0, 8'd1);
    expect_at(71, "drop_st1",    3'b011, 1'b0, 8'd1);
    expect_at(74, "drop_gap",    3'b011, 1'b0, 8'd1);
    expect_at(75, "drop_st2",    3'b111, 1'b1, 8'd1);
    drain();

    // Soft reset in RUN drops everything on the sampling edge.
    expect_at(78, "soft_pre", 3'b111, 1'b1, 8'd1);
    drain();
    soft_rst_req = 1'b1;
    at_edge(79);
    soft_rst_req = 1'b0;
    expect_at(79, "soft_drop", 3'b000, 1'b0, 8'd1);
    expect_at(86, "soft_wait", 3'b000, 1'b0, 8'd1);
    expect_at(87, "soft_st0",  3'b001, 1'b0, 8'd1);
    expect_at(91, "soft_st1",  3'b011, 1'b0, 8'd1);
    expect_at(95, "soft_st2",  3'b111, 1'b1, 8'd1);
    drain();

    // Async resetn mid-RELEASE, then the full sequence repeats.
    at_edge(97);
    soft_rst_req = 1'b1;
    at_edge(98);
    soft_rst_req = 1'b0;
    expect_at(98,  "soft2_drop", 3'b000, 1'b0, 8'd1);
    expect_at(106, "soft2_st0",  3'b001, 1'b0, 8'd1);
    expect_at(108, "mid_rel",    3'b001, 1'b0, 8'd1);
    drain();
    #3;
    resetn = 1'b0;
    #1;
    expect_at(edge_cnt, "async_rst", 3'b000, 1'b0, 8'd0);
    drain();
    at_edge(110);
    resetn = 1'b1;
    expect_at(120, "rerun_pre", 3'b000, 1'b0, 8'd0);
    expect_at(121, "rerun_st0", 3'b001, 1'b0, 8'd0);
    expect_at(125, "rerun_st1", 3'b011, 1'b0, 8'd0);
    expect_at(129, "rerun_st2", 3'b111, 1'b1, 8'd0);
    drain();

    // Filtered loss coincides with soft request: loss wins and is counted.
    at_edge(131);
    locked = 1'b0;
    expect_at(136, "both_pre", 3'b111, 1'b1, 8'd0);
    drain();
    soft_rst_req = 1'b1;
    at_edge(137);
    soft_rst_req = 1'b0;
    locked = 1'b1;
    expect_at(137, "both_drop", 3'b000, 1'b0, 8'd1);
    expect_at(147, "both_wait", 3'b000, 1'b0, 8'd1);
    expect_at(148, "both_st0",  3'b001, 1'b0, 8'd1);
    drain();

    // Repeated forced losses saturate the counter.
    for (int i = 0; i < 300; i++) begin
      b = edge_cnt;
      locked = 1'b1;
      at_edge(b + 12);
      locked = 1'b0;
      at_edge(b + 19);
      if (i == 252) begin
        expect_at(edge_cnt, "sat_254", 3'b000, 1'b0, 8'd254);
        drain();
      end
    end
    expect_at(edge_cnt, "sat_255", 3'b000, 1'b0, 8'd255);
    drain();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
